id_scan_arbiter: RTL and testbench

Shares one identifier-recognizer core between NREQ character-stream requesters. Each requester is granted for one whole string, which ends at a DELIM byte.
The arbiter streams the granted requester's bytes into the core under a valid/ready handshake. It counts identifier occurrences, meaning rising edges of the core's match output, and reports the count back with the requester index.
Sits between the text-source channels and the single recognizer instance in the lexer path.

---
 rtl/id_scan_pkg.sv | 11 +
 rtl/id_rec_core.sv | 19 +
 rtl/id_scan_arbiter.sv | 85 ++++++++
 tb/tb_id_scan_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/id_scan_pkg.sv
// id_scan_pkg: shared state encodings and character-class helpers for the identifier scan arbiter
package id_scan_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;
  typedef enum logic [1:0] {S0, S1, S2} core_t;
  function automatic logic is_letter(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction
  function automatic logic is_digit(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction
endpackage

// File: rtl/id_rec_core.sv
// id_rec_core: identifier recognizer, out high on a digit once a letter has been seen in the current word
module id_rec_core import id_scan_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       clr,
  input  logic [7:0] char,
  output logic       out
);
  core_t st;
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      st  <= S0;
      out <= 1'b0;
    end else if (ce) begin
      st  <= is_letter(char) ? S1 : (st != S0 && is_digit(char)) ? S2 : S0;
      out <= st != S0 && is_digit(char);
    end
endmodule

// File: rtl/id_scan_arbiter.sv
// id_scan_arbiter: round-robin sharing of one identifier recognizer, counting matches per delimited string
module id_scan_arbiter import id_scan_pkg::*; #(
  parameter int         NREQ  = 2,
  parameter logic [7:0] DELIM = 8'h00,
  parameter int         CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       char_in,
  input  logic [NREQ-1:0]         char_valid,
  output logic [NREQ-1:0]         char_ready,
  output logic [NREQ-1:0]         grant,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [CNT_W-1:0]        match_cnt,
  output logic                    hit
);
  localparam int IW = $clog2(NREQ);
  state_t           state;
  logic [IW-1:0]    ptr, pick;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       sel;
  logic             accept, acc_d, prev_out, out, clr;
  assign char_ready = state == SCAN ? grant : '0;
  assign accept     = |(char_valid & char_ready);
  assign clr        = state == IDLE && |req;
  assign cnt_nxt    = (acc_d && out && !prev_out && cnt != '1) ? cnt + 1'b1 : cnt;
  // Walking k downwards leaves the nearest requester after ptr as the final pick.
  always_comb begin
    pick = ptr;
    sel  = '0;
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % NREQ]) pick = IW'((int'(ptr) + k) % NREQ);
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) sel = char_in[8*i +: 8];
  end
  id_rec_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (accept),
    .clr   (clr),
    .char  (sel),
    .out   (out)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= IW'(NREQ - 1);
      cnt       <= '0;
      prev_out  <= 1'b0;
      acc_d     <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      hit       <= 1'b0;
    end else begin
      acc_d <= accept;
      done  <= 1'b0;
      cnt   <= cnt_nxt;
      if (acc_d) prev_out <= out;
      case (state)
        IDLE: if (|req) begin
          grant    <= NREQ'(1) << pick;
          ptr      <= pick;
          cnt      <= '0;
          prev_out <= 1'b0;
          state    <= SCAN;
        end
        SCAN: if (accept && sel == DELIM) state <= DRAIN;
        DRAIN: begin
          state     <= REPORT;
          done      <= 1'b1;
          done_id   <= ptr;
          match_cnt <= cnt_nxt;
          hit       <= cnt_nxt != '0;
        end
        REPORT: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_id_scan_arbiter.sv
// tb_id_scan_arbiter: table vectors, corner sequences and random strings against a word-level match model
module tb_id_scan_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, char_valid, char_ready, grant, char_ready_s, grant_s;
  logic [15:0] char_in;
  logic        done, hit, done_s, hit_s;
  logic        done_id, done_id_s;
  logic [7:0]  match_cnt;
  logic [1:0]  match_cnt_s;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  id_scan_arbiter #(.NREQ(2), .DELIM(8'h00), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .grant(grant), .done(done), .done_id(done_id),
    .match_cnt(match_cnt), .hit(hit)
  );

  id_scan_arbiter #(.NREQ(2), .DELIM(8'h00), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .req(req), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready_s), .grant(grant_s), .done(done_s), .done_id(done_id_s),
    .match_cnt(match_cnt_s), .hit(hit_s)
  );

  typedef struct {
    int    id;
    string s;
    bit    tog;
    int    cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A match starts on a digit whose word already contains a letter, where the previous byte did not match.
  function automatic int model(input string s);
    int c = 0;
    bit seen = 0, po = 0, o;
    logic [7:0] b;
    for (int k = 0; k < s.len(); k++) begin
      b = s[k];
      if (!((b >= "a" && b <= "z") || (b >= "A" && b <= "Z") || (b >= "0" && b <= "9"))) seen = 0;
      else if (!(b >= "0" && b <= "9")) seen = 1;
      o = seen && b >= "0" && b <= "9";
      if (o && !po) c++;
      po = o;
    end
    return c;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    char_valid = '0;
    char_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input int id, input string s, input bit tog, input bit hold, input int exp);
    int k, cyc, n, o;
    bit v, acc, bad;
    k = 0; cyc = 0; n = s.len(); o = id ^ 1; v = 0; bad = 0;
    req[id] = 1'b1;
    while (!grant[id] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("grant_latency", cyc, 1);
    chk("grant_onehot", grant, 32'(1) << id);
    if (!grant[id]) return;
    cyc = 0;
    while (k <= n && cyc < 100) begin
      v = tog ? !v : 1'b1;
      char_in[8*id +: 8] = (k < n) ? s[k] : 8'h00;
      char_valid[id] = v;
      char_valid[o] = 1'b1;
      char_in[8*o +: 8] = 8'($urandom);
      bad |= char_ready[o] || !char_ready[id];
      acc = v && char_ready[id];
      @(posedge clk); #1;
      cyc++;
      if (acc) k++;
    end
    char_valid = '0;
    if (!hold) req[id] = 1'b0;
    chk("ready_owner_only", bad, 0);
    chk("bytes_accepted", k, n + 1);
    chk("done_not_early", done, 0);
    @(posedge clk); #1;
    chk("done", done, 1);
    chk("done_sat", done_s, 1);
    chk("done_id", done_id, id);
    chk("match_cnt", match_cnt, exp > 255 ? 255 : exp);
    chk("hit", hit, exp != 0);
    chk("match_cnt_sat", match_cnt_s, exp > 3 ? 3 : exp);
    chk("hit_sat", hit_s, exp != 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("grant_release", grant, 0);
    chk("match_cnt_hold", match_cnt, exp > 255 ? 255 : exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  tbl[8];
    string s, alpha;
    int    len, ix, nd;
    tbl[0] = '{0, "ab12 c3", 1'b0, 2};
    tbl[1] = '{1, "a1b2", 1'b0, 2};
    tbl[2] = '{0, "123", 1'b0, 0};
    tbl[3] = '{1, "", 1'b0, 0};
    tbl[4] = '{0, "z7", 1'b1, 1};
    tbl[5] = '{1, "z7", 1'b1, 1};
    tbl[6] = '{0, "a1 a1 a1 a1 a1", 1'b0, 5};
    tbl[7] = '{1, "1a2", 1'b0, 1};
    alpha = "abXZ09q7 _.";

    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_hit", hit, 0);
    chk("rst_grant_sat", grant_s, 0);
    chk("rst_ready_sat", char_ready_s, 0);

    for (int t = 0; t < 8; t++) send(tbl[t].id, tbl[t].s, tbl[t].tog, 1'b0, tbl[t].cnt);

    do_reset();
    req = 2'b11;
    for (int t = 0; t < 4; t++) send(t % 2, "x9", 1'b0, 1'b1, 1);
    req = '0;

    req[0] = 1'b1;
    @(posedge clk); #1;
    chk("midscan_grant", grant, 1);
    char_in[7:0] = "a";
    char_valid[0] = 1'b1;
    @(posedge clk); #1;
    char_in[7:0] = "b";
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = '0;
    char_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_grant", grant, 0);
    chk("midrst_ready", char_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_match_cnt", match_cnt, 0);
    chk("midrst_hit", hit, 0);
    nd = 0;
    repeat (4) begin
      @(posedge clk); #1;
      nd += int'(done);
    end
    chk("midrst_no_done", nd, 0);
    send(0, "q5", 1'b0, 1'b0, 1);

    for (int r = 0; r < 16; r++) begin
      s = "";
      len = $urandom_range(0, 9);
      for (int j = 0; j < len; j++) begin
        ix = $urandom_range(0, alpha.len() - 1);
        s = {s, alpha.substr(ix, ix)};
      end
      send($urandom_range(0, 1), s, 1'($urandom_range(0, 1)), 1'b0, model(s));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
